// File: rtl/adc_capture_sequencer.sv
// ADC convert/capture sequencer: periodic cnv strobe, per-channel capture into an output FIFO.
// Define ADC_SEQ_TAG_EN to store each word's conversion tag in the FIFO and expose it on out_seq.
module adc_capture_sequencer #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int CNV_HIGH   = 4,
  parameter int CAP_DELAY  = 5,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [15:0]              period,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic                     clear_ovf,
  input  logic                     out_ready,
  output logic                     cnv,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [15:0]              out_seq,
  output logic                     overflow,
  output logic                     busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [15:0] MIN_P     = 16'(CNV_HIGH + CAP_DELAY + NUM_CH + 1);
  localparam logic [15:0] CONV_LAST = 16'(CNV_HIGH - 1);
  localparam logic [15:0] WAIT_LAST = 16'(CNV_HIGH + CAP_DELAY - 1);
  localparam logic [15:0] CAP_FIRST = 16'(CNV_HIGH + CAP_DELAY);
  localparam logic [15:0] CAP_LAST  = 16'(CNV_HIGH + CAP_DELAY + NUM_CH - 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CONV = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  // Reset asserts asynchronously but releases only on a clk_in edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_ni;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_ni     = rst_sync_q[1];

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  // ---------------------------------------------------------------------------
  // Sequencer. cnt_q counts cycles since CONV entry and doubles as phase timer.
  // ---------------------------------------------------------------------------
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] eff_q, eff_d;
  logic        cnv_q, cnv_d;
  logic        conv_entry;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    eff_d      = eff_q;
    conv_entry = 1'b0;
    case (state_q)
      S_IDLE: conv_entry = enable;
      S_CONV: if (cnt_q == CONV_LAST) state_d = S_WAIT;
      S_WAIT: if (cnt_q == WAIT_LAST) state_d = S_CAPT;
      S_CAPT: if (cnt_q == CAP_LAST)  state_d = S_HOLD;
      S_HOLD: begin
        if (cnt_q == eff_q - 16'd1) begin
          if (enable) conv_entry = 1'b1;
          else        state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE) cnt_d = cnt_q + 16'd1;
    if (state_d == S_IDLE) cnt_d = '0;
    if (conv_entry) begin
      state_d = S_CONV;
      cnt_d   = '0;
      eff_d   = (period < MIN_P) ? MIN_P : period;
    end
    cnv_d = (state_d == S_CONV);
  end

  always_ff @(posedge clk_in or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      eff_q   <= '0;
      cnv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eff_q   <= eff_d;
      cnv_q   <= cnv_d;
    end
  end

  assign cnv  = cnv_q;
  assign busy = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Capture: one channel per CAPTURE cycle, in channel order.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0][DATA_W-1:0] ch_words;
  logic [CH_W-1:0]               cap_ch;
  logic [DATA_W-1:0]             push_data;
  logic                          push;

  assign ch_words  = adc_data;
  assign push      = (state_q == S_CAPT);
  assign cap_ch    = CH_W'(cnt_q - CAP_FIRST);
  assign push_data = ch_words[cap_ch];

  // ---------------------------------------------------------------------------
  // Output FIFO. A full FIFO still accepts a push when a pop happens the same cycle.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, pop, wr_en, drop;

  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [CH_W-1:0]   mem_ch_q   [FIFO_DEPTH];

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CNT_FULL);
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle wins over clear_ovf.
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_ch_q[wr_ptr_q]   <= cap_ch;
    end
  end

  assign out_data = mem_data_q[rd_ptr_q];
  assign out_ch   = mem_ch_q[rd_ptr_q];
  assign overflow = ovf_q;

`ifdef ADC_SEQ_TAG_EN
  // seq_q is the tag the next conversion will take; tag_q belongs to the running one.
  logic [15:0] seq_q, seq_d, tag_q, tag_d;
  logic [15:0] mem_tag_q [FIFO_DEPTH];

  always_comb begin
    seq_d = seq_q;
    tag_d = tag_q;
    if (conv_entry) begin
      tag_d = seq_q;
      seq_d = seq_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_ni) begin
    if (!rst_ni) begin
      seq_q <= '0;
      tag_q <= '0;
    end else begin
      seq_q <= seq_d;
      tag_q <= tag_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_tag_q[wr_ptr_q] <= tag_q;
  end

  assign out_seq = mem_tag_q[rd_ptr_q];
`else
  assign out_seq = 16'h0;
`endif

endmodule

// File: doc/adc_capture_sequencer.md
ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of parallel ADC channels captured per conversion.
REQ-002 SHALL have parameter DATA_W, default 16: bits per ADC sample.
REQ-003 SHALL have parameter CNV_HIGH, default 4: cycles cnv is held high per conversion.
REQ-004 SHALL have parameter CAP_DELAY, default 5: cycles from cnv falling edge to first capture.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, power of two: output FIFO entries.
REQ-006 SHALL have ports: clk_in  input  1  sole clock, all logic on its rising edge.
REQ-007 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: enable  input  1  run conversions while high.
REQ-009 SHALL have ports: period  input  16  conversion period in clk_in cycles.
REQ-010 SHALL have ports: adc_data  input  NUM_CH*DATA_W  packed samples, channel 0 in LSBs.
REQ-011 SHALL have ports: clear_ovf  input  1  single-cycle overflow clear.
REQ-012 SHALL have ports: out_ready  input  1  consumer accepts word.
REQ-013 SHALL have ports: cnv  output  1  ADC convert strobe, registered.
REQ-014 SHALL have ports: out_valid  output  1  FIFO non-empty.
REQ-015 SHALL have ports: out_data  output  DATA_W  head sample.
REQ-016 SHALL have ports: out_ch  output  clog2(NUM_CH) (min 1)  head channel index.
REQ-017 SHALL have ports: out_seq  output  16  head conversion sequence tag.
REQ-018 SHALL have ports: overflow  output  1  sticky, sample dropped on full FIFO.
REQ-019 SHALL have ports: busy  output  1  state not IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> CONV -> WAIT -> CAPTURE -> HOLD -> CONV/IDLE.
REQ-021 SHALL leave IDLE for CONV on the cycle after enable is sampled high; period latched into eff_period at each CONV entry.
REQ-022 SHALL clamp eff_period to MIN_P = CNV_HIGH+CAP_DELAY+NUM_CH+1 when period < MIN_P (includes period 0).
REQ-023 SHALL drive cnv high for exactly CNV_HIGH cycles in CONV, then enter WAIT.
REQ-024 SHALL stay in WAIT exactly CAP_DELAY cycles, first WAIT cycle being the first cycle cnv is low.
REQ-025 SHALL, in CAPTURE, push one FIFO word per cycle for channels 0..NUM_CH-1 in order, sampling adc_data that cycle.
REQ-026 SHALL count a 16-bit period counter from CONV entry; next CONV entry occurs exactly eff_period cycles after previous one.
REQ-027 SHALL, when enable is low at HOLD expiry, go to IDLE; deasserting enable mid-sequence SHALL NOT truncate CONV/WAIT/CAPTURE.
REQ-028 SHALL increment seq tag (wraps 0xFFFF->0) at each CONV entry; all words of one conversion carry the same tag.
REQ-029 SHALL present FIFO head combinationally from storage; pop occurs when out_valid && out_ready.
REQ-030 SHALL, when full with no pop, drop the pushed word and set overflow; push on full with simultaneous pop SHALL be accepted.
REQ-031 SHALL give clear_ovf lower priority than a same-cycle drop (overflow stays 1).
REQ-032 SHALL wrap read/write pointers modulo FIFO_DEPTH; a word pushed to empty FIFO SHALL show out_valid the next cycle.

Reset
REQ-033 SHALL, on reset_n low, asynchronously force state IDLE, cnv 0, FIFO empty, out_valid 0, overflow 0, busy 0, seq 0, counters 0.
REQ-034 SHALL, on reset mid-conversion, drop cnv immediately and discard all FIFO contents.
REQ-035 SHALL release reset synchronously to clk_in and not start CONV until enable is sampled after release.

Configuration
REQ-036 SHALL honour macro ADC_SEQ_TAG_EN: defined, out_seq carries conversion tag stored per FIFO entry; undefined, tag storage is omitted and out_seq ties to 0.

Verification
REQ-037 SHALL cover: defaults, period=20, enable 1 -> cnv high 4 cycles every 20, words ch0,ch1 pushed 5..6 cycles after cnv fall.
REQ-038 SHALL cover: period=3 -> eff_period clamped to 12; cnv rising edges 12 cycles apart.
REQ-039 SHALL cover: out_ready=0, 5 conversions -> 8 words stored, overflow=1, remaining words dropped; clear_ovf then clears it.
REQ-040 SHALL cover: FIFO full, push and pop same cycle -> word accepted, overflow stays 0.
REQ-041 SHALL cover: enable low during WAIT -> both channels still captured, then IDLE, busy=0.
REQ-042 SHALL cover: reset_n low during CONV -> cnv 0 same cycle, out_valid 0, seq restarts at 0 (macro on).
